// File: rtl/s1_link_pkg.sv
// s1_link_pkg: frame geometry and FSM state types shared by the S1 link controller
package s1_link_pkg;
  localparam int FRAME_LEN = 21;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 18;
  localparam int NUM_WORDS = 8;
  typedef enum logic [2:0] {TX_IDLE, TX_READ, TX_LOAD, TX_SHIFT, TX_GAP, TX_DONE, TX_HOLD} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_SHIFT, RX_WRITE, RX_DONE, RX_HOLD} rx_state_t;
endpackage

// File: rtl/s1_link_shreg.sv
// link_shreg: frame shift register with parallel load, serial in and MSB-first serial out
module link_shreg #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic         sh_i,
  input  logic         sin_i,
  input  logic [W-1:0] ld_d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else if (clr_i) data_q <= '0;
    else if (ld_i) data_q <= ld_d_i;
    else if (sh_i) data_q <= {data_q[W-2:0], sin_i};
  end
  assign q_o = data_q;
endmodule

// File: rtl/s1_link.sv
// s1_link: S1 end of the sen/sd serial link; streams the register bank to S2 (updown=1)
// or writes frames received from S2 into the bank (updown=0)
module s1_link #(
  parameter int NUM_WORDS = 8,
  parameter int DATA_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              updown,
  output logic              S1_done,
  output logic              RB1_RW,
  output logic [2:0]        RB1_A,
  output logic [DATA_W-1:0] RB1_D,
  input  logic [DATA_W-1:0] RB1_Q,
  inout  wire               sen,
  inout  wire               sd
);
  import s1_link_pkg::*;
  localparam int FW = ADDR_W + DATA_W;
  tx_state_t tx_q, tx_d;
  rx_state_t rx_q, rx_d;
  logic          mode_q;
  logic [2:0]    word_q, word_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [3:0]    frm_q, frm_d;
  logic [FW-1:0] sr_q;
  logic          sr_ld, sr_sh, chg, tx_run, rx_run, last_frm;
  // a direction change spends one edge with both FSMs and all counters cleared
  assign chg      = updown != mode_q;
  assign tx_run   = updown & ~chg;
  assign rx_run   = ~updown & ~chg;
  assign last_frm = frm_q == 4'(NUM_WORDS - 1);
  always_comb begin
    tx_d   = TX_IDLE;
    rx_d   = RX_IDLE;
    word_d = '0;
    frm_d  = '0;
    cnt_d  = chg ? '0 : cnt_q;
    sr_ld  = 1'b0;
    sr_sh  = 1'b0;
    if (tx_run) begin
      word_d = word_q;
      case (tx_q)
        TX_IDLE: tx_d = TX_READ;
        TX_READ: tx_d = TX_LOAD;
        TX_LOAD: begin
          tx_d  = TX_SHIFT;
          sr_ld = 1'b1;
          cnt_d = '0;
        end
        TX_SHIFT: begin
          sr_sh = 1'b1;
          cnt_d = cnt_q + 5'd1;
          tx_d  = cnt_q == 5'(FRAME_LEN - 1) ? TX_GAP : TX_SHIFT;
        end
        TX_GAP: begin
          word_d = word_q + 3'd1;
          tx_d   = word_q == 3'(NUM_WORDS - 1) ? TX_DONE : TX_READ;
        end
        default: tx_d = TX_HOLD;
      endcase
    end
    if (rx_run) begin
      frm_d = frm_q;
      rx_d  = rx_q;
      case (rx_q)
        RX_IDLE, RX_SHIFT: begin
          if (!sen) begin
            sr_sh = 1'b1;
            cnt_d = &cnt_q ? cnt_q : cnt_q + 5'd1;
            rx_d  = RX_SHIFT;
          end else if (rx_q == RX_SHIFT) begin
            cnt_d = '0;
            rx_d  = cnt_q == 5'(FRAME_LEN) ? RX_WRITE : RX_IDLE;
          end
        end
        RX_WRITE: begin
          // the first bit of a back-to-back frame is captured during the write cycle
          frm_d = frm_q + 4'd1;
          sr_sh = !sen && !last_frm;
          cnt_d = {4'd0, sr_sh};
          rx_d  = last_frm ? RX_DONE : sen ? RX_IDLE : RX_SHIFT;
        end
        default: rx_d = RX_HOLD;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q   <= TX_IDLE;
      rx_q   <= RX_IDLE;
      mode_q <= 1'b1;
      word_q <= '0;
      cnt_q  <= '0;
      frm_q  <= '0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      mode_q <= updown;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      frm_q  <= frm_d;
    end
  end
  link_shreg #(.W(FW)) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (chg),
    .ld_i   (sr_ld),
    .sh_i   (sr_sh),
    .sin_i  (updown ? 1'b0 : sd),
    .ld_d_i ({word_q, RB1_Q}),
    .q_o    (sr_q)
  );
  assign S1_done = tx_q == TX_DONE || rx_q == RX_DONE;
  assign RB1_RW  = rx_q != RX_WRITE;
  assign RB1_A   = rx_q == RX_WRITE ? sr_q[FW-1 -: 3] : word_q;
  assign RB1_D   = rx_q == RX_WRITE ? sr_q[DATA_W-1:0] : '0;
  assign sen     = updown ? tx_q != TX_SHIFT : 1'bz;
  assign sd      = updown ? tx_q == TX_SHIFT && sr_q[FW-1] : 1'bz;
endmodule

// File: tb/tb_s1_link.sv
// tb_s1_link: scoreboard bench for s1_link; the bench plays the register bank and S2
module tb_s1_link;
  typedef struct packed {
    logic [20:0] v;
    int          t;
  } txe_t;
  logic        clk, rst, updown, tb_drv, tb_sen, tb_sd;
  wire         sen, sd;
  logic        S1_done, RB1_RW;
  logic [2:0]  RB1_A;
  logic [17:0] RB1_D, RB1_Q;
  logic [17:0] mem [8];
  txe_t        exp_tx[$];
  logic [20:0] exp_wr[$];
  int          exp_done[$];
  int          checks, errors, pe, last_wr, flen, fstart, mon_d, base;
  logic [20:0] fr;
  txe_t        mon_e;
  s1_link #(.NUM_WORDS(8), .DATA_W(18)) dut (
    .clk(clk), .rst(rst), .updown(updown), .S1_done(S1_done), .RB1_RW(RB1_RW),
    .RB1_A(RB1_A), .RB1_D(RB1_D), .RB1_Q(RB1_Q), .sen(sen), .sd(sd)
  );
  pullup (sen);
  pullup (sd);
  assign sen = tb_drv ? tb_sen : 1'bz;
  assign sd  = tb_drv ? tb_sd : 1'bz;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial pe = 0;
  always @(posedge clk) pe <= pe + 1;
  always @(posedge clk) if (RB1_RW) RB1_Q <= mem[RB1_A];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  // monitor: decodes frames on the bus, bank writes and done pulses, and pops expectations
  always @(negedge clk) begin
    if (!rst || !updown) flen = 0;
    else if (!sen) begin
      if (flen == 0) fstart = pe;
      fr = {fr[19:0], sd};
      flen++;
    end else if (flen != 0) begin
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected frame=%h len=%0d", fr, flen);
      end else begin
        mon_e = exp_tx.pop_front();
        chk("tx_len", flen, 21);
        chk("tx_frame", {11'd0, fr}, {11'd0, mon_e.v});
        chk("tx_start", fstart, mon_e.t);
      end
      flen = 0;
    end
    if (rst && !RB1_RW) begin
      last_wr = pe;
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected a=%0d d=%h", RB1_A, RB1_D);
      end else chk("wr_addr_data", {11'd0, RB1_A, RB1_D}, {11'd0, exp_wr.pop_front()});
    end
    if (rst && S1_done) begin
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected at edge %0d", pe);
      end else begin
        mon_d = exp_done.pop_front();
        chk("done_cycle", pe, mon_d < 0 ? last_wr + 1 : mon_d);
      end
    end
  end
  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 8; i++) mem[i] = rnd ? 18'($urandom) : 18'(i * 'h1111);
  endtask
  // expected frame k starts in cycle 24k+2 of a run whose READ of word 0 is at edge count b
  task automatic push_tx(input int b, input int n, input bit with_done);
    txe_t e;
    for (int k = 0; k < n; k++) begin
      e.v = {3'(k), mem[k]};
      e.t = b + 24 * k + 2;
      exp_tx.push_back(e);
    end
    if (with_done) exp_done.push_back(b + 192);
  endtask
  task automatic send(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      tb_sen = 0;
      tb_sd  = v[i];
      @(negedge clk);
    end
    tb_sen = 1;
    tb_sd  = 0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic rx_frame(input logic [20:0] v, input bit last, input int gap);
    exp_wr.push_back(v);
    if (last) exp_done.push_back(-1);
    send({11'd0, v}, 21, gap);
  endtask
  task automatic restart_rx();
    tb_drv = 0;
    updown = 1;
    @(negedge clk);
    updown = 0;
    tb_drv = 1;
    tb_sen = 1;
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_done"}, S1_done, 0);
    chk({p, "_rw"}, RB1_RW, 1);
    chk({p, "_a"}, RB1_A, 0);
    chk({p, "_d"}, RB1_D, 0);
    chk({p, "_sen"}, sen, 1);
    chk({p, "_sd"}, sd, 0);
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while (exp_tx.size() + exp_wr.size() + exp_done.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending tx=%0d wr=%0d done=%0d", exp_tx.size(), exp_wr.size(), exp_done.size());
      exp_tx.delete(); exp_wr.delete(); exp_done.delete();
    end
    repeat (4) @(negedge clk);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0; errors = 0; last_wr = 0; flen = 0; fstart = 0; fr = '0;
    rst = 0; updown = 1; tb_drv = 0; tb_sen = 1; tb_sd = 0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    chk_reset("reset");
    push_tx(pe + 1, 8, 1);
    rst = 1;
    drain(300);
    tb_drv = 1; tb_sen = 1; tb_sd = 0; updown = 0;
    repeat (2) @(negedge clk);
    for (int a = 7; a >= 0; a--) rx_frame({3'(a), 18'h2AAAA ^ 18'(a)}, a == 0, 1);
    drain(60);
    restart_rx();
    send($urandom, 20, 2);
    send($urandom, 22, 2);
    for (int k = 0; k < 8; k++) rx_frame(21'($urandom), k == 7, $urandom_range(1, 3));
    drain(60);
    fill_mem(1);
    tb_drv = 0; updown = 1; base = pe + 2;
    push_tx(base, 3, 0);
    while (pe != base + 84) @(negedge clk);
    chk("tog_sen_driven", sen, 0);
    updown = 0;
    #1;
    chk("tog_sen_released", sen, 1);
    chk("tog_rw", RB1_RW, 1);
    @(negedge clk);
    tb_drv = 1; tb_sen = 1;
    @(negedge clk);
    rx_frame(21'($urandom), 0, 2);
    drain(60);
    fill_mem(1);
    tb_drv = 0; updown = 1; base = pe + 2;
    push_tx(base, 1, 0);
    while (pe != base + 31) @(negedge clk);
    chk("rst_mid_sen", sen, 0);
    chk("rst_mid_a", RB1_A, 1);
    rst = 0;
    #1;
    chk_reset("rst_mid");
    chk("rst_mid_pending", exp_tx.size(), 0);
    exp_tx.delete();
    @(negedge clk);
    fill_mem(1);
    push_tx(pe + 1, 8, 1);
    rst = 1;
    drain(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
